// File: rtl/mycpu_pkg.sv
// Shared CPU package: I/O port address map and register bit positions.
package mycpu_pkg;

   typedef enum logic [1:0] {
      IO_RXDATA = 2'd0,
      IO_STATUS = 2'd1,
      IO_TXDATA = 2'd2,
      IO_CTRL   = 2'd3
   } io_addr_t;

   localparam int ST_RXNE    = 0;
   localparam int ST_TXF     = 1;
   localparam int ST_UNDR    = 2;
   localparam int ST_OVR     = 3;
   localparam int ST_CNT_LSB = 8;

   localparam int CTRL_CLR   = 0;
   localparam int CTRL_FLUSH = 1;

endpackage

// File: rtl/io_port_unit_if.sv
// CPU-side I/O bus bundle (strobe, direction, address, write and read data).
interface io_port_unit_if #(
   parameter int DW = 16
) ();
   logic          iom;
   logic          wen;
   logic [DW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;

   modport master (output iom, output wen, output addr, output wdata, input rdata);
   modport slave  (input iom, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; head word is presented combinationally and reads as 0 when empty.
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int DW    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [DW-1:0]            wdata,
   output logic [DW-1:0]            rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));
   assign count = cnt_q;
   assign rdata = empty ? '0 : mem_q[rd_ptr_q];

   // A push into a full FIFO is only legal when the head leaves on the same edge.
   always_comb begin
      do_pop   = pop && !empty && !flush;
      do_push  = push && (!full || do_pop) && !flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/io_port_unit.sv
// I/O responder: decodes IOR/IOW cycles onto an RX and a TX streaming FIFO.
module io_port_unit
   import mycpu_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int DW    = 16,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          iom_in,
   input  logic          wen_in,
   input  logic [DW-1:0] addr_in,
   input  logic [DW-1:0] data_in,
   output logic [DW-1:0] data_out,
   input  logic [DW-1:0] rx_data_in,
   input  logic          rx_valid_in,
   output logic          rx_ready_out,
   output logic [DW-1:0] tx_data_out,
   output logic          tx_valid_out,
   input  logic          tx_ready_in
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [AW-1:0] a_lo;
   logic          rd, wr;
   logic          sel_rxd, sel_st, sel_txd, sel_ctrl;
   logic          rx_push, rx_pop, rx_full, rx_empty;
   logic          tx_push, tx_pop, tx_full, tx_empty;
   logic          flush, clr, undr_set, ovr_set;
   logic [CW-1:0] rx_count, tx_count;
   logic [DW-1:0] rx_head;
   logic [DW-1:0] status;
   logic          undr_q, undr_d, ovr_q, ovr_d;
   logic          unused_bits;

   // Upper address bits alias onto the decoded low bits.
   assign unused_bits = ^{addr_in[DW-1:AW], tx_count};
   assign a_lo        = addr_in[AW-1:0];
   assign rd          = iom_in && wen_in;
   assign wr          = iom_in && !wen_in;
   assign sel_rxd     = (a_lo == AW'(IO_RXDATA));
   assign sel_st      = (a_lo == AW'(IO_STATUS));
   assign sel_txd     = (a_lo == AW'(IO_TXDATA));
   assign sel_ctrl    = (a_lo == AW'(IO_CTRL));

   assign rx_ready_out = !rx_full;
   assign tx_valid_out = !tx_empty;
   assign rx_push      = rx_valid_in && rx_ready_out;
   assign rx_pop       = rd && sel_rxd && !rx_empty;
   assign tx_pop       = tx_valid_out && tx_ready_in;
   assign tx_push      = wr && sel_txd && (!tx_full || tx_pop);
   assign flush        = wr && sel_ctrl && data_in[CTRL_FLUSH];
   assign clr          = wr && sel_ctrl && data_in[CTRL_CLR];
   assign undr_set     = rd && sel_rxd && rx_empty;
   assign ovr_set      = wr && sel_txd && tx_full && !tx_pop;

   always_comb begin
      status                  = '0;
      status[ST_RXNE]         = !rx_empty;
      status[ST_TXF]          = tx_full;
      status[ST_UNDR]         = undr_q;
      status[ST_OVR]          = ovr_q;
      status[ST_CNT_LSB +: 8] = 8'(rx_count);
   end

   always_comb begin
      data_out = '0;
      if (rd) begin
         if (sel_rxd)     data_out = rx_head;
         else if (sel_st) data_out = status;
      end
   end

   always_comb begin
      undr_d = (undr_q && !clr) || undr_set;
      ovr_d  = (ovr_q && !clr) || ovr_set;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         undr_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         undr_q <= undr_d;
         ovr_q  <= ovr_d;
      end
   end

   sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .flush(flush),
      .wdata(rx_data_in), .rdata(rx_head), .full(rx_full), .empty(rx_empty),
      .count(rx_count)
   );

   sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .flush(flush),
      .wdata(data_in), .rdata(tx_data_out), .full(tx_full), .empty(tx_empty),
      .count(tx_count)
   );

endmodule
